// File: rtl/led_panel_pkg.sv
// Shared constants for the HUB LED panel receive-side monitor.
package led_panel_pkg;

    localparam int unsigned COLS_DEF    = 64;
    localparam int unsigned ROWBITS_DEF = 6;

    // Monitor FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_LATCHED = 2'd2;
    localparam logic [1:0] ST_DISPLAY = 2'd3;

    // Bit positions of the colour pins in the packed pin vector and in rd_rgb
    localparam int unsigned PIN_R = 2;
    localparam int unsigned PIN_G = 1;
    localparam int unsigned PIN_B = 0;

    // Saturating 7-bit increment used by the shift counter
    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'd127) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/led_panel_chain.sv
// One colour's column shift chain, output latch and running ones count.
module led_panel_chain
    import led_panel_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            shift_i,
    input  logic            bit_i,
    input  logic            latch_i,
    output logic [COLS-1:0] lat_o,
    output logic [6:0]      count_o
);

    logic [COLS-1:0] sh_q, sh_d;
    logic [COLS-1:0] lat_q;
    logic [6:0]      ones_q, ones_d;
    logic [6:0]      count_q;

    // Shift applies before latch, so the latch path takes the _d values.
    // The ones counter subtracts the bit falling off the end to stay exact on overflow.
    always_comb begin
        sh_d   = sh_q;
        ones_d = ones_q;
        if (shift_i) begin
            sh_d   = {sh_q[COLS-2:0], bit_i};
            ones_d = ones_q + {6'd0, bit_i} - {6'd0, sh_q[COLS-1]};
        end
    end

    // Shift chain and latched copy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q    <= '0;
            ones_q  <= '0;
            lat_q   <= '0;
            count_q <= '0;
        end else begin
            sh_q   <= sh_d;
            ones_q <= ones_d;
            if (latch_i) begin
                lat_q   <= sh_d;
                count_q <= ones_d;
            end
        end
    end

    assign lat_o   = lat_q;
    assign count_o = count_q;

endmodule

// File: rtl/led_panel_monitor.sv
// Receive-side model of a HUB LED panel: rebuilds shift/latch/row state from the pins
// and reports pixel counts, row strobes and protocol errors.
module led_panel_monitor
    import led_panel_pkg::*;
#(
    parameter int unsigned COLS        = COLS_DEF,
    parameter int unsigned ROWBITS     = ROWBITS_DEF,
    parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               red_in,
    input  logic               green_in,
    input  logic               blue_in,
    input  logic               sclk_in,
    input  logic               latch_in,
    input  logic               blank_in,
    input  logic               aclk_in,
    input  logic               arst_in,
    input  logic               err_clear,
    input  logic [5:0]         rd_col,
    output logic [2:0]         rd_rgb,
    output logic [ROWBITS-1:0] row_idx,
    output logic               row_valid,
    output logic [6:0]         col_count,
    output logic [6:0]         red_count,
    output logic [6:0]         green_count,
    output logic [6:0]         blue_count,
    output logic               frame_pulse,
    output logic               err_overflow,
    output logic               err_shift_unblanked,
    output logic               err_latch_unblanked
);

    localparam int unsigned NPINS    = 8;
    localparam int unsigned IDX_SCLK = 3;
    localparam int unsigned IDX_LAT  = 4;
    localparam int unsigned IDX_BLNK = 5;
    localparam int unsigned IDX_ACLK = 6;
    localparam int unsigned IDX_ARST = 7;
    // blank and latch idle high, so they reset high to avoid phantom edges
    localparam logic [NPINS-1:0] SYNC_RST = 8'b0011_0000;
    localparam logic [4:0]       CTL_RST  = SYNC_RST[7:3];
    localparam logic [6:0]       COLS7    = 7'(COLS);

    logic [NPINS-1:0]                  pins;
    logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
    logic [NPINS-1:0]                  pin_s;
    logic [4:0]                        ctl_prev_q;
    logic [4:0]                        ctl_s;

    assign pins  = {arst_in, aclk_in, blank_in, latch_in, sclk_in, red_in, green_in, blue_in};
    assign pin_s = sync_q[SYNC_STAGES-1];
    assign ctl_s = pin_s[IDX_ARST:IDX_SCLK];

    // Input synchronizers plus one extra copy of the control pins for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= {SYNC_STAGES{SYNC_RST}};
            ctl_prev_q <= CTL_RST;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pins};
            ctl_prev_q <= ctl_s;
        end
    end

    logic sclk_rise, latch_fall, blank_fall, blank_rise, aclk_rise, arst_rise, arst_lvl;

    assign sclk_rise  =  ctl_s[IDX_SCLK-3] & ~ctl_prev_q[IDX_SCLK-3];
    assign latch_fall = ~ctl_s[IDX_LAT-3]  &  ctl_prev_q[IDX_LAT-3];
    assign blank_fall = ~ctl_s[IDX_BLNK-3] &  ctl_prev_q[IDX_BLNK-3];
    assign blank_rise =  ctl_s[IDX_BLNK-3] & ~ctl_prev_q[IDX_BLNK-3];
    assign aclk_rise  =  ctl_s[IDX_ACLK-3] & ~ctl_prev_q[IDX_ACLK-3];
    assign arst_rise  =  ctl_s[IDX_ARST-3] & ~ctl_prev_q[IDX_ARST-3];
    assign arst_lvl   =  ctl_s[IDX_ARST-3];

    logic [COLS-1:0] lat_r, lat_g, lat_b;

    led_panel_chain #(.COLS(COLS)) u_chain_r (
        .clk_i   (clk),
        .rst_ni  (reset),
        .shift_i (sclk_rise),
        .bit_i   (pin_s[PIN_R]),
        .latch_i (latch_fall),
        .lat_o   (lat_r),
        .count_o (red_count)
    );

    led_panel_chain #(.COLS(COLS)) u_chain_g (
        .clk_i   (clk),
        .rst_ni  (reset),
        .shift_i (sclk_rise),
        .bit_i   (pin_s[PIN_G]),
        .latch_i (latch_fall),
        .lat_o   (lat_g),
        .count_o (green_count)
    );

    led_panel_chain #(.COLS(COLS)) u_chain_b (
        .clk_i   (clk),
        .rst_ni  (reset),
        .shift_i (sclk_rise),
        .bit_i   (pin_s[PIN_B]),
        .latch_i (latch_fall),
        .lat_o   (lat_b),
        .count_o (blue_count)
    );

    logic [1:0]         state_q, state_d;
    logic [6:0]         shcnt_q, shcnt_d, shcnt_inc;
    logic [6:0]         col_q, col_d;
    logic [ROWBITS-1:0] row_q, row_d;
    logic               row_valid_q, row_valid_d;
    logic               frame_q, frame_d;
    logic               ovf_q, ovf_d;
    logic               shu_q, shu_d;
    logic               lau_q, lau_d;

    // Next-state: FSM, shift counter, row address, strobes and sticky errors
    always_comb begin
        state_d     = state_q;
        row_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (latch_fall)     state_d = ST_LATCHED;
                else if (sclk_rise) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (latch_fall) state_d = ST_LATCHED;
            end
            ST_LATCHED: begin
                if (blank_fall) begin
                    state_d     = ST_DISPLAY;
                    row_valid_d = 1'b1;
                end
            end
            ST_DISPLAY: begin
                if (blank_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        shcnt_inc = sclk_rise ? sat_inc7(shcnt_q) : shcnt_q;
        shcnt_d   = latch_fall ? 7'd0 : shcnt_inc;
        col_d     = latch_fall ? shcnt_inc : col_q;

        row_d = row_q;
        if (arst_lvl)       row_d = '0;
        else if (aclk_rise) row_d = row_q + ROWBITS'(1);

        frame_d = arst_rise;

        // A new error in the same cycle as err_clear wins
        ovf_d = (ovf_q & ~err_clear) | (sclk_rise & (shcnt_q == COLS7));
        shu_d = (shu_q & ~err_clear) | (sclk_rise & (state_q == ST_DISPLAY));
        lau_d = (lau_q & ~err_clear) | (latch_fall & (state_q == ST_DISPLAY));
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shcnt_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_valid_q <= 1'b0;
            frame_q     <= 1'b0;
            ovf_q       <= 1'b0;
            shu_q       <= 1'b0;
            lau_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shcnt_q     <= shcnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_valid_q <= row_valid_d;
            frame_q     <= frame_d;
            ovf_q       <= ovf_d;
            shu_q       <= shu_d;
            lau_q       <= lau_d;
        end
    end

    assign rd_rgb              = {lat_r[rd_col], lat_g[rd_col], lat_b[rd_col]};
    assign row_idx             = row_q;
    assign row_valid           = row_valid_q;
    assign col_count           = col_q;
    assign frame_pulse         = frame_q;
    assign err_overflow        = ovf_q;
    assign err_shift_unblanked = shu_q;
    assign err_latch_unblanked = lau_q;

endmodule

// File: tb/tb_led_panel_monitor.sv
// Randomized bench for led_panel_monitor against a queue-based panel model.
module tb_led_panel_monitor;

    localparam int HOLD = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
    logic       sclk_in = 1'b0, latch_in = 1'b1, blank_in = 1'b1;
    logic       aclk_in = 1'b0, arst_in = 1'b0, err_clear = 1'b0;
    logic [5:0] rd_col = '0;
    logic [2:0] rd_rgb;
    logic [5:0] row_idx;
    logic       row_valid, frame_pulse;
    logic [6:0] col_count, red_count, green_count, blue_count;
    logic       err_overflow, err_shift_unblanked, err_latch_unblanked;

    led_panel_monitor dut (
        .clk                 (clk),
        .reset               (reset),
        .red_in              (red_in),
        .green_in            (green_in),
        .blue_in             (blue_in),
        .sclk_in             (sclk_in),
        .latch_in            (latch_in),
        .blank_in            (blank_in),
        .aclk_in             (aclk_in),
        .arst_in             (arst_in),
        .err_clear           (err_clear),
        .rd_col              (rd_col),
        .rd_rgb              (rd_rgb),
        .row_idx             (row_idx),
        .row_valid           (row_valid),
        .col_count           (col_count),
        .red_count           (red_count),
        .green_count         (green_count),
        .blue_count          (blue_count),
        .frame_pulse         (frame_pulse),
        .err_overflow        (err_overflow),
        .err_shift_unblanked (err_shift_unblanked),
        .err_latch_unblanked (err_latch_unblanked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters: each strobe high cycle is one event
    int rv_seen = 0;
    int fp_seen = 0;
    always @(posedge clk) begin
        if (row_valid)   rv_seen++;
        if (frame_pulse) fp_seen++;
    end

    // Panel model: queues hold the last 64 bits shifted, newest at index 0
    bit q_r[$], q_g[$], q_b[$];
    bit lat_r[64], lat_g[64], lat_b[64];
    int m_cnt_r, m_cnt_g, m_cnt_b, m_col, m_nshift, m_row;
    int m_rv = 0, m_fp = 0;
    bit m_ovf, m_shu, m_lau;
    bit m_latched, m_disp, m_arst;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        q_r.delete(); q_g.delete(); q_b.delete();
        for (int i = 0; i < 64; i++) begin
            q_r.push_back(1'b0); q_g.push_back(1'b0); q_b.push_back(1'b0);
            lat_r[i] = 1'b0; lat_g[i] = 1'b0; lat_b[i] = 1'b0;
        end
        m_cnt_r = 0; m_cnt_g = 0; m_cnt_b = 0;
        m_col = 0; m_nshift = 0; m_row = 0;
        m_ovf = 0; m_shu = 0; m_lau = 0;
        m_latched = 0; m_disp = 0; m_arst = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(3);
    endtask

    task automatic do_shift(input bit r, input bit g, input bit b);
        @(negedge clk);
        red_in = r; green_in = g; blue_in = b; sclk_in = 1'b1;
        q_r.push_front(r); q_g.push_front(g); q_b.push_front(b);
        void'(q_r.pop_back()); void'(q_g.pop_back()); void'(q_b.pop_back());
        if (m_nshift == 64) m_ovf = 1;
        m_nshift++;
        if (m_disp) m_shu = 1;
        wait_cyc(HOLD);
        sclk_in = 1'b0;
        wait_cyc(HOLD);
    endtask

    task automatic do_latch();
        @(negedge clk);
        latch_in = 1'b0;
        m_cnt_r = 0; m_cnt_g = 0; m_cnt_b = 0;
        for (int i = 0; i < 64; i++) begin
            lat_r[i] = q_r[i]; lat_g[i] = q_g[i]; lat_b[i] = q_b[i];
            m_cnt_r += int'(q_r[i]); m_cnt_g += int'(q_g[i]); m_cnt_b += int'(q_b[i]);
        end
        m_col    = (m_nshift > 127) ? 127 : m_nshift;
        m_nshift = 0;
        if (m_disp) m_lau = 1;
        else        m_latched = 1;
        wait_cyc(HOLD);
        latch_in = 1'b1;
        wait_cyc(HOLD);
    endtask

    task automatic set_blank(input bit v);
        @(negedge clk);
        blank_in = v;
        if (!v && m_latched && !m_disp) begin
            m_disp = 1; m_latched = 0; m_rv++;
        end else if (v && m_disp) begin
            m_disp = 0;
        end
        wait_cyc(HOLD);
    endtask

    task automatic set_arst(input bit v);
        @(negedge clk);
        arst_in = v;
        if (v && !m_arst) m_fp++;
        m_arst = v;
        if (v) m_row = 0;
        wait_cyc(HOLD);
    endtask

    task automatic pulse_aclk();
        @(negedge clk);
        aclk_in = 1'b1;
        if (!m_arst) m_row = (m_row + 1) % 64;
        wait_cyc(HOLD);
        aclk_in = 1'b0;
        wait_cyc(HOLD);
    endtask

    task automatic pulse_err_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        m_ovf = 0; m_shu = 0; m_lau = 0;
        wait_cyc(1);
    endtask

    task automatic check_all(input string tag);
        int c;
        check_val({tag, " red_count"},   32'(red_count),   32'(m_cnt_r));
        check_val({tag, " green_count"}, 32'(green_count), 32'(m_cnt_g));
        check_val({tag, " blue_count"},  32'(blue_count),  32'(m_cnt_b));
        check_val({tag, " col_count"},   32'(col_count),   32'(m_col));
        check_val({tag, " row_idx"},     32'(row_idx),     32'(m_row));
        check_val({tag, " err_ovf"},     32'(err_overflow),        32'(m_ovf));
        check_val({tag, " err_shu"},     32'(err_shift_unblanked), 32'(m_shu));
        check_val({tag, " err_lau"},     32'(err_latch_unblanked), 32'(m_lau));
        check_val({tag, " row_valid_n"}, 32'(rv_seen), 32'(m_rv));
        check_val({tag, " frame_n"},     32'(fp_seen), 32'(m_fp));
        for (int k = 0; k < 3; k++) begin
            c = int'($urandom_range(0, 63));
            rd_col = 6'(c);
            #1;
            check_val({tag, " rd_rgb"}, 32'(rd_rgb), 32'({lat_r[c], lat_g[c], lat_b[c]}));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout rows_done=? got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset();
        check_all("reset");

        // Full 64-column load: red solid, blue alternating
        for (int i = 0; i < 64; i++) do_shift(1'b1, 1'b0, 1'(i % 2));
        do_latch();
        set_blank(1'b0);
        check_all("full64");
        set_blank(1'b1);

        // Short 63-column load: oldest column keeps prior data
        for (int i = 0; i < 63; i++) do_shift(1'($urandom()), 1'($urandom()), 1'($urandom()));
        do_latch();
        set_blank(1'b0);
        check_all("short63");
        set_blank(1'b1);

        // Overflow: 70 shifts of green
        for (int i = 0; i < 70; i++) do_shift(1'b0, 1'b1, 1'b0);
        do_latch();
        check_all("overflow");
        pulse_err_clear();
        check_all("ovf_clear");

        // Row address: arst holds zero, then 64 aclk pulses wrap
        set_arst(1'b1);
        pulse_aclk();
        pulse_aclk();
        check_all("arst_hold");
        set_arst(1'b0);
        for (int i = 0; i < 64; i++) begin
            pulse_aclk();
            check_val("row_step", 32'(row_idx), 32'(m_row));
        end
        check_all("row_wrap");

        // Shift and latch during display
        for (int i = 0; i < 64; i++) do_shift(1'($urandom()), 1'($urandom()), 1'($urandom()));
        do_latch();
        set_blank(1'b0);
        do_shift(1'b1, 1'b1, 1'b1);
        do_latch();
        check_all("unblanked");
        set_blank(1'b1);
        pulse_err_clear();
        check_all("unbl_clear");

        // Reset in the middle of a load, then a clean load
        for (int i = 0; i < 20; i++) do_shift(1'b1, 1'b1, 1'b1);
        do_reset();
        check_all("mid_reset");
        for (int i = 0; i < 64; i++) do_shift(1'($urandom()), 1'($urandom()), 1'($urandom()));
        do_latch();
        set_blank(1'b0);
        check_all("after_reset");
        set_blank(1'b1);

        // Random rows with random length, errors, clears and address activity
        for (int row = 0; row < 8; row++) begin
            int n;
            n = int'($urandom_range(1, 70));
            for (int i = 0; i < n; i++) do_shift(1'($urandom()), 1'($urandom()), 1'($urandom()));
            do_latch();
            set_blank(1'b0);
            if ($urandom_range(0, 1) == 1) do_shift(1'($urandom()), 1'($urandom()), 1'($urandom()));
            check_all("rand_disp");
            set_blank(1'b1);
            if ($urandom_range(0, 3) == 0) begin
                set_arst(1'b1);
                set_arst(1'b0);
            end
            repeat ($urandom_range(0, 3)) pulse_aclk();
            if ($urandom_range(0, 2) == 0) pulse_err_clear();
            check_all("rand_row");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
